// File: rtl/fmrv32im_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// Single request/acknowledge handshake; the acknowledge completes in the same cycle.
interface fmrv32im_lsu_if;
    logic        D_MEM_REQ;
    logic [31:0] D_MEM_ADDR;
    logic [3:0]  D_MEM_WSTB;
    logic [31:0] D_MEM_WDATA;
    logic        D_MEM_ACK;
    logic [31:0] D_MEM_RDATA;

    modport master (
        output D_MEM_REQ, D_MEM_ADDR, D_MEM_WSTB, D_MEM_WDATA,
        input  D_MEM_ACK, D_MEM_RDATA
    );

    modport slave (
        input  D_MEM_REQ, D_MEM_ADDR, D_MEM_WSTB, D_MEM_WDATA,
        output D_MEM_ACK, D_MEM_RDATA
    );
endinterface

// File: rtl/fmrv32im_lsu.sv
// Load/store unit: one bus transaction per memory op, misaligned accesses trap
// without touching the bus. Loads return aligned, sign/zero-extended data.
module fmrv32im_lsu (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 INST_LB,
    input  logic                 INST_LH,
    input  logic                 INST_LW,
    input  logic                 INST_LBU,
    input  logic                 INST_LHU,
    input  logic                 INST_SB,
    input  logic                 INST_SH,
    input  logic                 INST_SW,
    input  logic [31:0]          ADDR,
    input  logic                 ADDR_VALID,
    input  logic [31:0]          RS2,
    output logic                 LSU_BUSY,
    output logic                 LSU_DONE,
    output logic                 LSU_RD_VALID,
    output logic [31:0]          LSU_RDATA,
    output logic                 EXC_MISALIGN,
    fmrv32im_lsu_if.master       dmem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, TRAP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state, state_nxt;
    logic [29:0] addr_q;
    logic [3:0]  wstb_q, wstb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ld_q, uns_q;
    size_t       sz_q, sz_d;
    logic [1:0]  ofs_q;
    logic [31:0] rdata_q, ext;

    logic is_ld, is_half, is_word, is_mem, misalign, start, accept;

    assign is_ld    = INST_LB | INST_LH | INST_LW | INST_LBU | INST_LHU;
    assign is_half  = INST_LH | INST_LHU | INST_SH;
    assign is_word  = INST_LW | INST_SW;
    assign is_mem   = is_ld | INST_SB | INST_SH | INST_SW;
    assign misalign = (is_half & ADDR[0]) | (is_word & (ADDR[1:0] != 2'b00));
    assign start    = (state == IDLE) & ADDR_VALID & is_mem;
    assign accept   = start & ~misalign;

    always_comb begin
        wstb_d  = 4'b0000;
        wdata_d = 32'h0;
        sz_d    = SZ_W;
        if (INST_LB | INST_LBU)      sz_d = SZ_B;
        else if (INST_LH | INST_LHU) sz_d = SZ_H;
        if (INST_SB) begin
            sz_d    = SZ_B;
            wstb_d  = 4'b0001 << ADDR[1:0];
            wdata_d = {4{RS2[7:0]}};
        end else if (INST_SH) begin
            sz_d    = SZ_H;
            wstb_d  = ADDR[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{RS2[15:0]}};
        end else if (INST_SW) begin
            wstb_d  = 4'b1111;
            wdata_d = RS2;
        end
    end

    // Lane extraction works on the live bus data; it is only captured during the ACK cycle.
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    always_comb begin
        lane_b = dmem.D_MEM_RDATA[{ofs_q, 3'b000} +: 8];
        lane_h = ofs_q[1] ? dmem.D_MEM_RDATA[31:16] : dmem.D_MEM_RDATA[15:0];
        ext    = dmem.D_MEM_RDATA;
        case (sz_q)
            SZ_B:    ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            SZ_H:    ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: ext = dmem.D_MEM_RDATA;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = misalign ? TRAP : REQ;
            REQ:  if (dmem.D_MEM_ACK) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            TRAP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q  <= 30'h0;
            wstb_q  <= 4'b0000;
            wdata_q <= 32'h0;
            ld_q    <= 1'b0;
            uns_q   <= 1'b0;
            sz_q    <= SZ_W;
            ofs_q   <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                addr_q  <= ADDR[31:2];
                wstb_q  <= wstb_d;
                wdata_q <= wdata_d;
                ld_q    <= is_ld;
                uns_q   <= INST_LBU | INST_LHU;
                sz_q    <= sz_d;
                ofs_q   <= ADDR[1:0];
            end
            if (state == REQ && dmem.D_MEM_ACK && ld_q) rdata_q <= ext;
        end
    end

    always_comb begin
        LSU_BUSY         = (state != IDLE);
        LSU_DONE         = (state == DONE) | (state == TRAP);
        LSU_RD_VALID     = (state == DONE) & ld_q;
        EXC_MISALIGN     = (state == TRAP);
        LSU_RDATA        = rdata_q;
        dmem.D_MEM_REQ   = (state == REQ);
        dmem.D_MEM_ADDR  = {addr_q, 2'b00};
        dmem.D_MEM_WSTB  = wstb_q;
        dmem.D_MEM_WDATA = wdata_q;
    end

endmodule

// File: doc/fmrv32im_lsu.md
# fmrv32im_lsu

Load/store unit for the fmrv32im core. Consumes the effective address registered by the ALU for LB/LH/LW/LBU/LHU/SB/SH/SW, runs one request/acknowledge transaction on the data-memory port, and returns aligned, extended load data or a store completion to the core. Sits between the execute stage and the data-memory bus. Misaligned accesses are trapped without touching the bus.

## Interface
- Parameters: none.
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_SB, INST_SH, INST_SW  in  1 each  one-hot decoded memory op; stable while ADDR_VALID is high
- ADDR  in  32  effective address (rs1+imm) from the ALU
- ADDR_VALID  in  1  ALU result valid; asserted for every ALU op
- RS2  in  32  store data
- LSU_BUSY  out  1  transaction in progress; the core holds its inputs while high
- LSU_DONE  out  1  one-cycle completion pulse: load, store, or trap
- LSU_RD_VALID  out  1  one-cycle pulse with LSU_DONE, loads only
- LSU_RDATA  out  32  extended load result; holds until the next load completes
- EXC_MISALIGN  out  1  one-cycle pulse with LSU_DONE on a misaligned access
- D_MEM_REQ  out  1  bus request
- D_MEM_ADDR  out  32  word address, {ADDR[31:2],2'b00}
- D_MEM_WSTB  out  4  byte write strobes; 4'b0000 means read
- D_MEM_WDATA  out  32  lane-replicated store data
- D_MEM_ACK  in  1  bus acknowledge; completes the request in the same cycle
- D_MEM_RDATA  in  32  read data; valid only while D_MEM_ACK is high

## Operation
- States: IDLE, REQ, DONE, TRAP.
- IDLE: start condition is ADDR_VALID & (any memory INST_*).
  - ADDR_VALID with no memory INST_* is ignored.
  - Start and misaligned → TRAP.
  - Start and aligned → latch word address, strobes, write data, op type and ADDR[1:0]; go to REQ.
- Misaligned means:
  - LH/LHU/SH with ADDR[0]=1.
  - LW/SW with ADDR[1:0]≠0.
  - Byte ops are never misaligned.
- REQ:
  - D_MEM_REQ=1; ADDR, WSTB and WDATA are stable until ACK.
  - On D_MEM_ACK: capture D_MEM_RDATA for loads; go to DONE.
  - Unbounded wait; no timeout.
- DONE: LSU_DONE=1, plus LSU_RD_VALID=1 for loads; → IDLE.
- TRAP: LSU_DONE=1 and EXC_MISALIGN=1; → IDLE. No bus activity.
- LSU_BUSY=1 in REQ, DONE and TRAP. ADDR_VALID is ignored outside IDLE.
- Store strobes and data:
  - SB: WSTB=1<<ADDR[1:0], WDATA={4{RS2[7:0]}}.
  - SH: WSTB=ADDR[1]?4'b1100:4'b0011, WDATA={2{RS2[15:0]}}.
  - SW: WSTB=4'b1111, WDATA=RS2.
- Loads: WSTB=0, WDATA=0.
- Load extraction:
  - Byte lane = RDATA[8*ADDR[1:0]+:8].
  - Half lane = RDATA[16*ADDR[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- D_MEM_ACK outside REQ is ignored.

## Timing
- Reset (async assert):
  - All outputs are 0 and state is IDLE, including LSU_RDATA=0.
  - D_MEM_REQ drops immediately, even mid-transaction.
  - A late ACK after reset is ignored.
- Cycle 0: start sampled in IDLE. Cycle 1: D_MEM_REQ=1 (all outputs registered).
- ACK in cycle k≥1 → LSU_DONE in cycle k+1. Minimum latency is 2 cycles; back-to-back starts are possible every 3 cycles.
- Misaligned: EXC_MISALIGN and LSU_DONE in cycle 1; D_MEM_REQ never rises.
- A new start is accepted in the cycle after DONE or TRAP.
- ACK in the same cycle REQ first rises is legal.
- REQ drops in the cycle after ACK.

## Test plan
- LW at 0x100, ACK in cycle 1 with RDATA=0xDEADBEEF:
  - D_MEM_ADDR=0x100, WSTB=0.
  - LSU_DONE and LSU_RD_VALID in cycle 2; LSU_RDATA=0xDEADBEEF.
- LB at 0x103 with RDATA=0x80FF_FFFF → LSU_RDATA=0xFFFFFF80.
- LBU at 0x103 with the same RDATA → LSU_RDATA=0x00000080.
- LHU at 0x102 with RDATA=0x8001_0000 → 0x00008001.
- SB at 0x201 with RS2=0x12345678 → WSTB=4'b0010, WDATA=0x78787878, D_MEM_ADDR=0x200.
- SH at 0x202 with RS2=0xAABB → WSTB=4'b1100, WDATA=0xAABBAABB.
- LW at 0x102 → EXC_MISALIGN and LSU_DONE in cycle 1; D_MEM_REQ stays 0 throughout.
- SH at 0x203 → same trap behaviour as the LW case.
- SW with ACK withheld for 5 cycles:
  - REQ, ADDR, WSTB and WDATA are constant.
  - A toggling ADDR_VALID/ADDR during the wait has no effect.
  - LSU_DONE appears one cycle after ACK.
- Reset asserted while in REQ:
  - D_MEM_REQ=0 asynchronously; all outputs 0.
  - A subsequent ACK produces no LSU_DONE.
  - The next LW completes normally.
